// File: rtl/traffic_pkg.sv
// Shared phase encoding and lamp patterns for the two-road intersection controller.
package traffic_pkg;

    typedef enum logic [3:0] {
        ARED_A = 4'd0,
        A_LEFT = 4'd1,
        A_GRN  = 4'd2,
        A_YEL  = 4'd3,
        ARED_B = 4'd4,
        B_LEFT = 4'd5,
        B_GRN  = 4'd6,
        B_YEL  = 4'd7,
        FLASH  = 4'd8,
        EMERG  = 4'd9
    } phase_e;

    // Lamp order is {left, green, yellow, red}.
    localparam logic [3:0] L_RED  = 4'b0001;
    localparam logic [3:0] L_YEL  = 4'b0010;
    localparam logic [3:0] L_GRN  = 4'b0100;
    localparam logic [3:0] L_LEFT = 4'b1000;
    localparam logic [3:0] L_OFF  = 4'b0000;

    function automatic phase_e next_ring(phase_e p);
        case (p)
            ARED_A:  return A_LEFT;
            A_LEFT:  return A_GRN;
            A_GRN:   return A_YEL;
            A_YEL:   return ARED_B;
            ARED_B:  return B_LEFT;
            B_LEFT:  return B_GRN;
            B_GRN:   return B_YEL;
            default: return ARED_A;
        endcase
    endfunction

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// Mode requests in, lamps/phase/countdowns/tick out; slave is the controller side.
interface traffic_phase_ctrl_if
    import traffic_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) ();

    logic             night_mode;
    logic             emergency;
    logic [3:0]       A_lights;
    logic [3:0]       B_lights;
    phase_e           phase;
    logic [CNT_W-1:0] A_countdown;
    logic [CNT_W-1:0] B_countdown;
    logic             tick_o;

    modport master (
        output night_mode,
        output emergency,
        input  A_lights,
        input  B_lights,
        input  phase,
        input  A_countdown,
        input  B_countdown,
        input  tick_o
    );

    modport slave (
        input  night_mode,
        input  emergency,
        output A_lights,
        output B_lights,
        output phase,
        output A_countdown,
        output B_countdown,
        output tick_o
    );

endinterface

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-clock tick every TICK_DIV clocks.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection controller: a single phase FSM owns both roads so lamps cannot conflict.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter int unsigned T_LEFT   = 15,
    parameter int unsigned T_GREEN  = 40,
    parameter int unsigned T_YEL    = 5,
    parameter int unsigned T_ALLRED = 2,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    traffic_phase_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] LD_LEFT   = CNT_W'(T_LEFT - 1);
    localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] LD_YEL    = CNT_W'(T_YEL - 1);
    localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] CD_MAX    = {CNT_W{1'b1}};

    // Time from the end of the current phase to the waiting road's left turn.
    localparam int unsigned WAIT_AFTER_ARED = T_LEFT + T_GREEN + T_YEL;
    localparam int unsigned WAIT_AFTER_LEFT = T_GREEN + T_YEL + T_ALLRED;
    localparam int unsigned WAIT_AFTER_GRN  = T_YEL + T_ALLRED;
    localparam int unsigned WAIT_AFTER_YEL  = T_ALLRED;

    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             flash_q, flash_d;
    logic             tick;

    logic [3:0]       a_lights, b_lights;
    logic [31:0]      a_cd_raw, b_cd_raw;
    logic [31:0]      t_left;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    function automatic logic [CNT_W-1:0] load_of(phase_e p);
        case (p)
            ARED_A, ARED_B: return LD_ALLRED;
            A_LEFT, B_LEFT: return LD_LEFT;
            A_GRN, B_GRN:   return LD_GREEN;
            default:        return LD_YEL;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat(logic [31:0] v);
        return (v > 32'(CD_MAX)) ? CD_MAX : v[CNT_W-1:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= ARED_A;
            timer_q <= LD_ALLRED;
            flash_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            timer_q <= timer_d;
            flash_q <= flash_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        timer_d = timer_q;
        flash_d = flash_q;
        if (bus.emergency && (phase_q inside {A_LEFT, A_GRN, B_LEFT, B_GRN})) begin
            // Cut straight to the road's yellow without waiting for a tick.
            phase_d = (phase_q == A_LEFT || phase_q == A_GRN) ? A_YEL : B_YEL;
            timer_d = LD_YEL;
        end else if (bus.emergency && phase_q == FLASH) begin
            phase_d = EMERG;
            flash_d = 1'b0;
        end else if (phase_q == EMERG) begin
            if (!bus.emergency) begin
                phase_d = ARED_A;
                timer_d = LD_ALLRED;
            end
        end else if (phase_q == FLASH) begin
            if (tick) begin
                if (!bus.night_mode) begin
                    phase_d = ARED_A;
                    timer_d = LD_ALLRED;
                    flash_d = 1'b0;
                end else begin
                    flash_d = ~flash_q;
                end
            end
        end else if (tick) begin
            if (timer_q == '0) begin
                if (bus.emergency) begin
                    phase_d = EMERG;
                end else if (bus.night_mode && (phase_q == A_YEL || phase_q == B_YEL)) begin
                    phase_d = FLASH;
                    flash_d = 1'b1;
                end else begin
                    phase_d = next_ring(phase_q);
                    timer_d = load_of(next_ring(phase_q));
                end
            end else begin
                timer_d = timer_q - CNT_W'(1);
            end
        end
    end

    assign t_left = 32'(timer_q) + 32'd1;

    always_comb begin
        a_lights = L_RED;
        b_lights = L_RED;
        a_cd_raw = '0;
        b_cd_raw = '0;
        unique case (phase_q)
            ARED_A: begin
                a_cd_raw = t_left;
                b_cd_raw = t_left + WAIT_AFTER_ARED;
            end
            A_LEFT: begin
                a_lights = L_LEFT;
                a_cd_raw = t_left;
                b_cd_raw = t_left + WAIT_AFTER_LEFT;
            end
            A_GRN: begin
                a_lights = L_GRN;
                a_cd_raw = t_left;
                b_cd_raw = t_left + WAIT_AFTER_GRN;
            end
            A_YEL: begin
                a_lights = L_YEL;
                a_cd_raw = t_left;
                b_cd_raw = t_left + WAIT_AFTER_YEL;
            end
            ARED_B: begin
                b_cd_raw = t_left;
                a_cd_raw = t_left + WAIT_AFTER_ARED;
            end
            B_LEFT: begin
                b_lights = L_LEFT;
                b_cd_raw = t_left;
                a_cd_raw = t_left + WAIT_AFTER_LEFT;
            end
            B_GRN: begin
                b_lights = L_GRN;
                b_cd_raw = t_left;
                a_cd_raw = t_left + WAIT_AFTER_GRN;
            end
            B_YEL: begin
                b_lights = L_YEL;
                b_cd_raw = t_left;
                a_cd_raw = t_left + WAIT_AFTER_YEL;
            end
            FLASH: begin
                a_lights = flash_q ? L_YEL : L_OFF;
                b_lights = flash_q ? L_YEL : L_OFF;
            end
            default: begin
                a_lights = L_RED;
                b_lights = L_RED;
            end
        endcase
    end

    assign bus.A_lights    = a_lights;
    assign bus.B_lights    = b_lights;
    assign bus.phase       = phase_q;
    assign bus.A_countdown = sat(a_cd_raw);
    assign bus.B_countdown = sat(b_cd_raw);
    assign bus.tick_o      = tick;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed plus random checks of traffic_phase_ctrl against a tick-level reference model.
module tb_traffic_phase_ctrl;
    import traffic_pkg::*;

    localparam int DIV = 4;
    localparam int TL  = 3;
    localparam int TG  = 5;
    localparam int TY  = 2;
    localparam int TR  = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic em  = 1'b0;
    logic nm  = 1'b0;

    traffic_phase_ctrl_if #(.CNT_W(8)) bus ();

    assign bus.emergency  = em;
    assign bus.night_mode = nm;

    traffic_phase_ctrl #(
        .TICK_DIV (DIV),
        .T_LEFT   (TL),
        .T_GREEN  (TG),
        .T_YEL    (TY),
        .T_ALLRED (TR),
        .CNT_W    (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: phase number, ticks still to run in it, flash lamp state, clocks into the tick.
    int len[8] = '{TR, TL, TG, TY, TR, TL, TG, TY};
    int m_ph, m_rem, m_flash, m_pre;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int sat8(int v);
        return (v > 255) ? 255 : v;
    endfunction

    function automatic int lamp_of(int step_in_road);
        case (step_in_road)
            1:       return 8;
            2:       return 4;
            3:       return 2;
            default: return 1;
        endcase
    endfunction

    // Ticks until the waiting road's left turn; the guard right after the current one is not counted.
    function automatic int wait_cd();
        int target = (m_ph < 4) ? 5 : 1;
        int sum = m_rem;
        int k = (m_ph + 1) % 8;
        while (k != target) begin
            if (!((k % 4 == 0) && (m_ph % 4 == 0))) sum += len[k];
            k = (k + 1) % 8;
        end
        return sat8(sum);
    endfunction

    task automatic model_reset();
        m_ph = 0;
        m_rem = TR;
        m_flash = 0;
        m_pre = 0;
    endtask

    task automatic model_clock(logic e, logic n);
        bit tk;
        tk = (m_pre == DIV - 1);
        m_pre = (m_pre + 1) % DIV;
        if (e && m_ph < 8 && (m_ph % 4 == 1 || m_ph % 4 == 2)) begin
            m_ph = (m_ph < 4) ? 3 : 7;
            m_rem = TY;
        end else if (e && m_ph == 8) begin
            m_ph = 9;
            m_flash = 0;
        end else if (m_ph == 9) begin
            if (!e) begin
                m_ph = 0;
                m_rem = TR;
            end
        end else if (m_ph == 8) begin
            if (tk) begin
                if (!n) begin
                    m_ph = 0;
                    m_rem = TR;
                    m_flash = 0;
                end else begin
                    m_flash ^= 1;
                end
            end
        end else if (tk) begin
            m_rem--;
            if (m_rem == 0) begin
                if (e) m_ph = 9;
                else if (n && m_ph % 4 == 3) begin
                    m_ph = 8;
                    m_flash = 1;
                end else begin
                    m_ph = (m_ph + 1) % 8;
                    m_rem = len[m_ph];
                end
            end
        end
    endtask

    task automatic check_all();
        int ea, eb, ca, cb;
        ea = 1; eb = 1; ca = 0; cb = 0;
        if (m_ph < 8) begin
            if (m_ph < 4) begin
                ea = lamp_of(m_ph % 4);
                ca = sat8(m_rem);
                cb = wait_cd();
            end else begin
                eb = lamp_of(m_ph % 4);
                cb = sat8(m_rem);
                ca = wait_cd();
            end
        end else if (m_ph == 8) begin
            ea = m_flash ? 2 : 0;
            eb = ea;
        end
        chk("phase", 32'(bus.phase), m_ph);
        chk("A_lights", 32'(bus.A_lights), ea);
        chk("B_lights", 32'(bus.B_lights), eb);
        chk("A_countdown", 32'(bus.A_countdown), ca);
        chk("B_countdown", 32'(bus.B_countdown), cb);
        chk("tick_o", 32'(bus.tick_o), (m_pre == DIV - 1) ? 1 : 0);
        if (m_ph != 8) begin
            chk("conflict", 32'((bus.A_lights > 4'd1) && (bus.B_lights > 4'd1)), 0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_clock(em, nm);
        #1;
        check_all();
    endtask

    task automatic run_until(string tag, int ph, int budget);
        int n = 0;
        while (m_ph != ph && n < budget) begin
            step();
            n++;
        end
        chk(tag, 32'(bus.phase), ph);
    endtask

    task automatic check_reset_values(string tag);
        chk({tag, "_phase"}, 32'(bus.phase), 0);
        chk({tag, "_A_lights"}, 32'(bus.A_lights), 1);
        chk({tag, "_B_lights"}, 32'(bus.B_lights), 1);
        chk({tag, "_A_cd"}, 32'(bus.A_countdown), 1);
        chk({tag, "_B_cd"}, 32'(bus.B_countdown), 11);
        chk({tag, "_tick"}, 32'(bus.tick_o), 0);
    endtask

    initial begin
        model_reset();
        #1;
        check_reset_values("por");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Free run of one full ring: 22 ticks.
        repeat (22 * DIV) step();
        chk("ring_wrap", 32'(bus.phase), 0);

        // Asynchronous reset in the middle of a phase.
        repeat (23) step();
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        model_reset();
        step();
        rst = 1'b0;
        repeat (8) step();

        // Emergency during A green: forced yellow, then all-red hold.
        run_until("reach_A_GRN", 2, 200);
        em = 1'b1;
        step();
        chk("em_to_A_YEL", 32'(bus.phase), 3);
        run_until("em_hold", 9, 40);
        repeat (5) step();
        em = 1'b0;
        step();
        chk("em_release", 32'(bus.phase), 0);

        // Night mode entered at the end of B yellow, then released.
        run_until("reach_B_YEL", 7, 200);
        nm = 1'b1;
        run_until("enter_flash", 8, 40);
        repeat (12) step();
        nm = 1'b0;
        run_until("flash_exit", 0, 20);
        run_until("after_flash_left", 1, 20);

        // Emergency preempts flashing immediately.
        nm = 1'b1;
        run_until("flash_again", 8, 200);
        repeat (3) step();
        em = 1'b1;
        step();
        chk("flash_to_emerg", 32'(bus.phase), 9);
        em = 1'b0;
        nm = 1'b0;
        step();

        // Emergency and night together through a yellow end: emergency wins, night honoured later.
        run_until("reach_A_YEL", 3, 200);
        em = 1'b1;
        nm = 1'b1;
        run_until("both_emerg", 9, 40);
        em = 1'b0;
        step();
        run_until("night_after_emerg", 8, 200);
        nm = 1'b0;
        run_until("night_done", 0, 20);

        // Random levels on both requests, with occasional mid-cycle resets.
        repeat (3000) begin
            if ($urandom_range(0, 39) == 0) em = ~em;
            if ($urandom_range(0, 29) == 0) nm = ~nm;
            if ($urandom_range(0, 499) == 0) begin
                #2;
                rst = 1'b1;
                #1;
                model_reset();
                check_all();
                step();
                rst = 1'b0;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
